// File: rtl/motor_cmd_spi_slave.sv
// Mode-0 SPI slave that takes duty/direction commands from the host MCU and
// streams back a status word. A command watchdog zeroes the duty output if the host goes quiet.
module motor_cmd_spi_slave #(
    parameter int DUTY_CYCLE_WIDTH = 10,
    parameter int FRAME_BITS       = 16,
    parameter int WATCHDOG_CYCLES  = 2000000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        spi_sck,
    input  logic                        spi_mosi,
    input  logic                        spi_ncs,
    output logic                        spi_miso,
    input  logic [2:0]                  hall,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    output logic                        direction,
    output logic                        frame_strobe,
    output logic                        timeout,
    output logic [7:0]                  error_count
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Bit order in the synchroniser vectors: [2]=ncs, [1]=mosi, [0]=sck
    logic [2:0] pin_vec;
    logic [2:0] meta_reg, sync_reg, sync_d_reg;

    logic sck_rise, sck_fall, ncs_rise, ncs_fall, mosi_bit;

    logic [FRAME_BITS-1:0]       rx_reg;
    logic [FRAME_BITS-1:0]       tx_reg;
    logic [FRAME_BITS-1:0]       status_word;
    logic [CNT_W-1:0]            bit_cnt_reg;
    logic [WD_W-1:0]             wd_cnt_reg;
    logic [DUTY_CYCLE_WIDTH-1:0] duty_reg;
    logic                        direction_reg;
    logic                        strobe_reg;
    logic                        timeout_reg;
    logic [7:0]                  error_count_reg;
    logic                        commit_valid;

    assign pin_vec = {spi_ncs, spi_mosi, spi_sck};

    // ncs resets to the "low" view so a host already selecting us at reset
    // release produces no falling edge; it must deselect and reselect first.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_reg   <= '0;
            sync_reg   <= '0;
            sync_d_reg <= '0;
        end else begin
            meta_reg   <= pin_vec;
            sync_reg   <= meta_reg;
            sync_d_reg <= sync_reg;
        end
    end

    assign sck_rise = sync_reg[0] & ~sync_d_reg[0];
    assign sck_fall = ~sync_reg[0] & sync_d_reg[0];
    assign ncs_rise = sync_reg[2] & ~sync_d_reg[2];
    assign ncs_fall = ~sync_reg[2] & sync_d_reg[2];
    assign mosi_bit = sync_reg[1];

    always_comb begin
        status_word                    = '0;
        status_word[FRAME_BITS-1]      = timeout_reg;
        status_word[FRAME_BITS-2 -: 3] = hall;
        status_word[7:0]               = error_count_reg;
    end

    assign commit_valid = (state_reg == COMMIT) && (bit_cnt_reg == BIT_FULL);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ncs_fall) state_next = SHIFT;
            SHIFT:   if (ncs_rise) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        spi_miso = 1'b0;
        if (state_reg == SHIFT) begin
            spi_miso = tx_reg[FRAME_BITS-1];
        end
    end

    // Shift registers and bit counter
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_reg      <= '0;
            tx_reg      <= '0;
            bit_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ncs_fall) begin
                        bit_cnt_reg <= '0;
                        tx_reg      <= status_word;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx_reg <= {rx_reg[FRAME_BITS-2:0], mosi_bit};
                        if (bit_cnt_reg != BIT_SAT) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Command outputs, error counter and watchdog; a valid commit beats expiry
    always_ff @(posedge clock) begin
        if (reset) begin
            duty_reg        <= '0;
            direction_reg   <= 1'b0;
            strobe_reg      <= 1'b0;
            timeout_reg     <= 1'b1;
            error_count_reg <= '0;
            wd_cnt_reg      <= '0;
        end else begin
            strobe_reg <= 1'b0;
            if (commit_valid) begin
                duty_reg      <= rx_reg[DUTY_CYCLE_WIDTH-1:0];
                direction_reg <= rx_reg[FRAME_BITS-1];
                strobe_reg    <= 1'b1;
                timeout_reg   <= 1'b0;
                wd_cnt_reg    <= '0;
            end else begin
                if ((state_reg == COMMIT) && (error_count_reg != 8'hFF)) begin
                    error_count_reg <= error_count_reg + 8'd1;
                end
                if (wd_cnt_reg == WD_LAST) begin
                    timeout_reg <= 1'b1;
                    duty_reg    <= '0;
                end else begin
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign duty_cycle   = duty_reg;
    assign direction    = direction_reg;
    assign frame_strobe = strobe_reg;
    assign timeout      = timeout_reg;
    assign error_count  = error_count_reg;

endmodule

// File: tb/tb_motor_cmd_spi_slave.sv
// Bench for motor_cmd_spi_slave: random and directed SPI frames against a frame-level
// model of the command outputs, status word and error counter, plus a short-watchdog instance.
module tb_motor_cmd_spi_slave;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_ncs = 1'b1;
    logic [2:0] hall = 3'b000;

    logic       spi_miso, frame_strobe, direction, timeout;
    logic [9:0] duty_cycle;
    logic [7:0] error_count;

    logic       miso_w, strobe_w, dir_w, timeout_w;
    logic [9:0] duty_w;
    logic [7:0] err_w;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level reference model of the main instance
    logic [9:0]  m_duty;
    logic        m_dir;
    logic [7:0]  m_err;
    logic        m_timeout;
    logic [31:0] last_miso;

    always #5 clock = ~clock;

    motor_cmd_spi_slave dut (
        .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_ncs(spi_ncs), .spi_miso(spi_miso), .hall(hall), .duty_cycle(duty_cycle),
        .direction(direction), .frame_strobe(frame_strobe), .timeout(timeout),
        .error_count(error_count)
    );

    motor_cmd_spi_slave #(.WATCHDOG_CYCLES(100)) dut_wd (
        .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_ncs(spi_ncs), .spi_miso(miso_w), .hall(hall), .duty_cycle(duty_w),
        .direction(dir_w), .frame_strobe(strobe_w), .timeout(timeout_w),
        .error_count(err_w)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_duty = '0;
        m_dir = 1'b0;
        m_err = '0;
        m_timeout = 1'b1;
    endtask

    // Clock n bits out MSB first at sck = clock/8, capturing MISO on each rising sck
    task automatic shift_bits(input int n, input logic [31:0] data);
        last_miso = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = data[i];
            tick(4);
            spi_sck = 1'b1;
            last_miso = {last_miso[30:0], spi_miso};
            tick(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic apply_frame(input int nbits, input logic [31:0] data, input logic [2:0] h);
        logic [15:0] status;
        logic [31:0] exp_miso;
        logic [9:0]  old_duty;
        logic        old_dir;
        bit          valid;
        hall = h;
        status = {m_timeout, h, 4'b0000, m_err};
        if (nbits >= 16) exp_miso = {16'b0, status} << (nbits - 16);
        else             exp_miso = {16'b0, status} >> (16 - nbits);
        spi_ncs = 1'b0;
        tick(8);
        shift_bits(nbits, data);
        tick(4);
        chk("miso_status", last_miso, exp_miso);
        old_duty = m_duty;
        old_dir = m_dir;
        valid = (nbits == 16);
        if (valid) begin
            m_duty = data[9:0];
            m_dir = data[15];
            m_timeout = 1'b0;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
        spi_ncs = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("frame_strobe", 32'(frame_strobe), (valid && k == 4) ? 32'd1 : 32'd0);
            if (k == 3) begin
                chk("duty_before_commit", 32'(duty_cycle), 32'(old_duty));
                chk("dir_before_commit", 32'(direction), 32'(old_dir));
            end
            if (k == 4) begin
                chk("duty_cycle", 32'(duty_cycle), 32'(m_duty));
                chk("direction", 32'(direction), 32'(m_dir));
                chk("error_count", 32'(error_count), 32'(m_err));
                chk("timeout", 32'(timeout), 32'(m_timeout));
            end
            if (k == 6) chk("miso_idle", 32'(spi_miso), 32'd0);
        end
    endtask

    initial begin
        int nb;
        model_reset();

        // Reset release with ncs high and no traffic
        tick(4);
        reset = 1'b0;
        tick(3);
        chk("rst_duty", 32'(duty_cycle), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd1);
        chk("rst_err", 32'(error_count), 32'd0);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        chk("rst_strobe", 32'(frame_strobe), 32'd0);
        chk("rst_wd_timeout", 32'(timeout_w), 32'd1);

        // Directed valid frame
        apply_frame(16, 32'h8155, 3'b000);
        chk("dir_8155", 32'(direction), 32'd1);
        chk("duty_8155", 32'(duty_cycle), 32'h155);

        // Short and long frames are rejected
        apply_frame(15, $urandom, 3'b010);
        apply_frame(17, $urandom, 3'b110);
        chk("err_after_two_bad", 32'(error_count), 32'd2);

        // Status readback with known hall / error / timeout
        apply_frame(16, $urandom, 3'b101);
        chk("status_5002", last_miso, 32'h5002);

        // Randomised mix of valid and malformed frames
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            apply_frame(nb, $urandom, 3'($urandom_range(0, 7)));
        end
        apply_frame(16, 32'h0000, 3'b001);

        // 300 very short frames saturate the error counter
        for (int i = 0; i < 300; i++) begin
            apply_frame($urandom_range(1, 3), $urandom, 3'($urandom_range(0, 7)));
        end
        chk("err_saturated", 32'(error_count), 32'd255);

        // Watchdog: expiry exactly 100 cycles after the commit on the short instance
        apply_frame(16, 32'h8200, 3'b011);
        chk("wd_strobe_seen_duty", 32'(duty_w), 32'h200);
        tick(97);
        chk("wd_before_timeout", 32'(timeout_w), 32'd0);
        chk("wd_before_duty", 32'(duty_w), 32'h200);
        tick(1);
        chk("wd_at_timeout", 32'(timeout_w), 32'd1);
        chk("wd_at_duty", 32'(duty_w), 32'd0);
        chk("wd_dir_kept", 32'(dir_w), 32'd1);
        chk("main_no_timeout", 32'(timeout), 32'd0);
        chk("main_duty_kept", 32'(duty_cycle), 32'h200);
        // A duty-zero frame is valid and clears the timeout
        apply_frame(16, 32'h8000, 3'b011);
        chk("wd_cleared", 32'(timeout_w), 32'd0);
        chk("wd_zero_duty", 32'(duty_w), 32'd0);
        chk("wd_zero_dir", 32'(dir_w), 32'd1);

        // Reset after bit 8, release with ncs still low, finish the frame
        spi_ncs = 1'b0;
        tick(8);
        shift_bits(8, 32'h00A5);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(1);
        chk("midrst_duty", 32'(duty_cycle), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd1);
        chk("midrst_err", 32'(error_count), 32'd0);
        shift_bits(8, 32'h0033);
        chk("midrst_miso", last_miso, 32'd0);
        tick(4);
        spi_ncs = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("midrst_strobe", 32'(frame_strobe), 32'd0);
        end
        chk("midrst_err_after", 32'(error_count), 32'd0);
        chk("midrst_duty_after", 32'(duty_cycle), 32'd0);

        // The next full frame is accepted normally
        apply_frame(16, $urandom, 3'b100);
        apply_frame(16, $urandom, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/motor_cmd_spi_slave.md
Name: motor_cmd_spi_slave

Overview:
- SPI slave, mode 0, that receives motor commands from the host MCU and produces `duty_cycle` and `direction` for the hall-commutation/phase-driver stage directly downstream.
- Returns a status word (watchdog flag, current hall state, frame error count) to the MCU on MISO during the same frame.
- A command watchdog forces `duty_cycle` to 0 when the MCU stops sending, so a dead host cannot leave the motor driven.

Parameters:
- DUTY_CYCLE_WIDTH, 10, width of the duty_cycle field and output; must equal the phase-driver duty width.
- FRAME_BITS, 16, bits per SPI frame; must be >= DUTY_CYCLE_WIDTH+1 and >= 12.
- WATCHDOG_CYCLES, 2000000, clock cycles without a valid frame before timeout (100 ms at 20 MHz).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI clock from MCU, asynchronous to clock.
- spi_mosi  in  1  SPI data from MCU, asynchronous.
- spi_ncs  in  1  SPI chip select, active low, asynchronous.
- spi_miso  out  1  SPI data to MCU.
- hall  in  3  current hall sensor state, echoed in the status word.
- duty_cycle  out  DUTY_CYCLE_WIDTH  commanded duty to the commutation stage.
- direction  out  1  commanded rotation direction, 1 = reverse.
- frame_strobe  out  1  one-cycle pulse when a valid frame is committed.
- timeout  out  1  watchdog expired; duty_cycle is held at 0 while set.
- error_count  out  8  saturating count of malformed frames.

Behaviour:
- Synchronisation:
  - spi_sck, spi_mosi and spi_ncs each pass through a 2-FF synchroniser.
  - Edges are detected on the synchronised signals.
  - spi_sck frequency must be <= clock/8.
- Reset values: duty_cycle=0, direction=0, frame_strobe=0, timeout=1, error_count=0, spi_miso=0, state=IDLE, watchdog counter=0.
  - The motor stays off until the first valid frame arrives.
- States:
  - IDLE: wait for a synchronised ncs falling edge, then go to SHIFT.
    - If ncs is already low when reset releases, stay in IDLE until ncs goes high and then falls again, so no partial frame is accepted.
  - SHIFT, on ncs falling entry:
    - Clear the bit counter.
    - Load the tx shift register with the status word: {timeout, hall[2:0], zeros, error_count[7:0]}, MSB first, zero padded to FRAME_BITS.
    - spi_miso = tx MSB.
  - SHIFT, on each sck rising edge:
    - Shift mosi into the rx register, MSB first.
    - Increment the bit counter, saturating at FRAME_BITS+1.
  - SHIFT, on each sck falling edge: shift tx left; spi_miso = new MSB.
  - SHIFT, on ncs rising edge: go to COMMIT.
  - COMMIT, lasts exactly 1 cycle:
    - If bit counter == FRAME_BITS: duty_cycle <= rx[DUTY_CYCLE_WIDTH-1:0], direction <= rx[FRAME_BITS-1], frame_strobe=1, timeout<=0, watchdog counter cleared.
    - Bits between the direction bit and the duty field are ignored.
    - Otherwise (short or long frame): outputs unchanged, error_count increments, saturating at 255.
    - Then go to IDLE.
- spi_miso is driven 0 whenever the state is not SHIFT.
- Latency: duty_cycle updates 4 clocks after the spi_ncs pin rises (2 sync, 1 edge detect, 1 commit).
- Watchdog:
  - The counter increments every cycle the module is not in COMMIT-with-valid-frame.
  - When the count reaches WATCHDOG_CYCLES-1, timeout<=1 and duty_cycle<=0 on the next cycle; direction is retained and the counter holds.
  - A valid commit in the same cycle as expiry wins: the new duty is applied and timeout stays 0.
- Duty zero: a valid frame with duty 0 is legal and clears timeout.
- Reset mid-frame: the frame is discarded, the reset values above apply, and no error is counted.

Test Plan:
- Reset release with ncs high, no SPI traffic -> duty_cycle=0, timeout=1, error_count=0, spi_miso=0.
- Valid 16-bit frame 0x8155 (sck = clock/8) -> direction=1, duty_cycle=0x155, single frame_strobe pulse 4 clocks after ncs rises, timeout=0.
- Status readback: hall=3'b101, error_count=2, timeout=0 -> MISO bits during the frame = 0x5002 (bit15=0, bits14:12=101, bits7:0=0x02).
- Malformed frames of 15 bits and 17 bits -> duty_cycle/direction unchanged, no frame_strobe, error_count +1 each; 300 bad frames saturate error_count at 255.
- WATCHDOG_CYCLES=100: valid frame duty=0x200 then idle -> timeout=1 and duty_cycle=0 exactly 100 cycles after commit; the next valid frame clears timeout.
- Assert reset after bit 8 of a frame, release with ncs still low, then finish the frame -> no commit, no error; the next full frame is accepted normally.
